// File: rtl/register_file.sv
// register_file: 32x32 register file with two registered read ports, one write port, bypass, combinational debug port
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] debug_reg,
  output logic [DATA_WIDTH-1:0] debug_data
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd1, r_rd2;
  logic                  w_we, w_byp1, w_byp2;
  logic [DATA_WIDTH-1:0] w_rd1, w_rd2;
  assign w_we   = reg_write && (write_reg != '0);
  assign w_byp1 = w_we && (write_reg == read_reg1);
  assign w_byp2 = w_we && (write_reg == read_reg2);
  // Operand selection: forward write data on a same-edge hit, index 0 is hardwired zero
  always_comb begin
    w_rd1 = w_byp1 ? write_data : (read_reg1 == '0) ? '0 : r_regs[read_reg1];
    w_rd2 = w_byp2 ? write_data : (read_reg2 == '0) ? '0 : r_regs[read_reg2];
  end
  // Register array and operand registers; reset wins over any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else begin
      if (w_we) r_regs[write_reg] <= write_data;
      r_rd1 <= w_rd1;
      r_rd2 <= w_rd2;
    end
  end
  assign read_data1 = r_rd1;
  assign read_data2 = r_rd2;
  assign debug_data = (debug_reg == '0) ? '0 : r_regs[debug_reg];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector bench for register_file
module tb_register_file;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg, debug_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2, debug_data;
  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk(clk), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(read_data1), .read_data2(read_data2),
    .debug_reg(debug_reg), .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  dbg;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] dbg);
    reset = rst; reg_write = we; write_reg = wr; write_data = wd;
    read_reg1 = rr1; read_reg2 = rr2; debug_reg = dbg;
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 5'd9,  32'hA5A5A5A5, 5'd5, 5'd9, 5'd5, 32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5, 5'd9, 5'd9, 32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd3,  32'h00000007, 5'd4, 5'd5, 5'd3, 32'h0,        32'h0,        32'h00000007};
    vecs[5]  = '{1'b0, 1'b1, 5'd4,  32'hFFFFFFF9, 5'd0, 5'd0, 5'd4, 32'h0,        32'h0,        32'hFFFFFFF9};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3, 5'd4, 5'd0, 32'h00000007, 32'hFFFFFFF9, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 5'd0,  32'h12345678, 5'd0, 5'd3, 5'd0, 32'h0,        32'h00000007, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 5'd7,  32'h11111111, 5'd7, 5'd6, 5'd7, 32'h11111111, 32'h0,        32'h11111111};
    vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd7, 5'd7, 32'h11111111, 32'h11111111, 32'h11111111};
    vecs[10] = '{1'b0, 1'b1, 5'd7,  32'h22222222, 5'd7, 5'd7, 5'd7, 32'h22222222, 32'h22222222, 32'h22222222};
    vecs[11] = '{1'b0, 1'b1, 5'd8,  32'hCAFEF00D, 5'd7, 5'd3, 5'd8, 32'h22222222, 32'h00000007, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 1'b0, 5'd3,  32'hFFFFFFFF, 5'd3, 5'd3, 5'd3, 32'h00000007, 32'h00000007, 32'h00000007};

    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].rst, vecs[k].we, vecs[k].wr, vecs[k].wd, vecs[k].rr1, vecs[k].rr2, vecs[k].dbg);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rd1", k), read_data1, vecs[k].e1);
      chk($sformatf("vec%0d_rd2", k), read_data2, vecs[k].e2);
      chk($sformatf("vec%0d_dbg", k), debug_data, vecs[k].ed);
    end

    drive(1'b0, 1'b1, 5'd10, 32'h00000055, 5'd10, 5'd0, 5'd10);
    #2;
    chk("dbg_before_write_edge", debug_data, 32'h0);
    @(posedge clk); #1;
    chk("dbg_after_write_edge", debug_data, 32'h00000055);
    chk("rd1_bypass_r10", read_data1, 32'h00000055);

    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), sweep_val(i), 5'd0, 5'd0, 5'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
      @(posedge clk); #1;
      chk($sformatf("sweep_rd1_r%0d", i), read_data1, sweep_val(i));
      chk($sformatf("sweep_rd2_r%0d", 31 - i), read_data2, sweep_val(31 - i));
      chk($sformatf("sweep_dbg_r%0d", i), debug_data, sweep_val(i));
    end

    drive(1'b1, 1'bx, 5'd12, 32'h0000FFFF, 5'd12, 5'd31, 5'd12);
    @(posedge clk); #1;
    chk("midreset_rd1", read_data1, 32'h0);
    chk("midreset_rd2", read_data2, 32'h0);
    chk("midreset_dbg", debug_data, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd12, 5'd20);
    @(posedge clk); #1;
    chk("postreset_rd1_r31", read_data1, 32'h0);
    chk("postreset_rd2_r12", read_data2, 32'h0);
    chk("postreset_dbg_r20", debug_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Three-port general-purpose register file: 32 registers × 32 bits, two read ports, one write port.
- Sits directly upstream of the ALU. read_data1 and read_data2 drive the ALU's two 32-bit operand inputs.
- The write port is driven by the writeback stage (ALU result or load data).
- Reads are registered, so operands arrive one clock after the address, matching the ALU's clocked operand capture.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- read_reg1  input  ADDR_WIDTH  index for read port 1 (rs).
- read_reg2  input  ADDR_WIDTH  index for read port 2 (rt).
- write_reg  input  ADDR_WIDTH  index for write port (rd/rt).
- write_data  input  DATA_WIDTH  data to write.
- reg_write  input  1  write enable, sampled at rising edge.
- read_data1  output  DATA_WIDTH  registered contents of read_reg1 (ALU operand 1).
- read_data2  output  DATA_WIDTH  registered contents of read_reg2 (ALU operand 2).
- debug_reg  input  ADDR_WIDTH  index for combinational debug/observation port.
- debug_data  output  DATA_WIDTH  combinational contents of debug_reg (no bypass).

Behaviour:
- One clock (clk); reset is synchronous and active-high. The clock port is named clk and the reset port is named reset.
- Reset:
  - On a rising edge with reset=1, all 32 registers clear to 0, and read_data1 and read_data2 clear to 0.
  - reset has priority over reg_write; a write in the same cycle is discarded.
  - Reset asserted mid-sequence discards any pending write. Outputs are 0 on the cycle after the reset edge.
- Write:
  - On a rising edge with reset=0, reg_write=1 and write_reg≠0, register[write_reg] ← write_data.
  - Writes to index 0 are ignored.
- Register 0: always reads 0 on every port, including bypass. It is never stored nonzero.
- Read latency: 1 cycle.
  - At rising edge N, read_dataK ← value of register[read_regK] as seen by the bypass rule below.
  - The output holds until the next edge, and updates every edge irrespective of reg_write.
- Write-before-read bypass, per port independently:
  - Applies when reg_write=1, write_reg==read_regK and write_reg≠0 at the same edge.
  - In that case read_dataK ← write_data at that edge, i.e. the new value, not the stale one.
  - Both ports may bypass simultaneously when read_reg1==read_reg2==write_reg.
- Simultaneous events:
  - A read of one register and a write of a different register in the same cycle do not interact.
  - With read_reg1==read_reg2 and no write, both outputs are equal.
- debug_data: purely combinational, debug_data = register[debug_reg] (0 for index 0). It reflects a write only after the write edge, and is 0 during and after reset.
- Widths:
  - No arithmetic; data passes unmodified.
  - All 32 bits are stored. Sign interpretation belongs to the downstream ALU.
- Unknown inputs: X on reg_write while reset=1 has no effect.
- Storage: a flop array is implemented (no inferred RAM primitives required). Reset clears all entries in one cycle.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert reset one cycle → read_reg1=5 gives read_data1=0 one cycle later; debug_reg=5 gives debug_data=0.
- Basic write/read latency: write r3=0x00000007, r4=0xFFFFFFF9 (−7) on consecutive edges; then read_reg1=3, read_reg2=4 → exactly one edge later read_data1=0x00000007 and read_data2=0xFFFFFFF9; both are 0 before that edge.
- r0 protection: reg_write=1, write_reg=0, write_data=0x12345678, read_reg1=0 on the same edge → read_data1=0 (no bypass); debug_reg=0 gives 0 afterwards.
- Bypass: r7 holds 0x11111111; at one edge set reg_write=1, write_reg=7, write_data=0x22222222, read_reg1=read_reg2=7 → after that edge read_data1=read_data2=0x22222222; debug_data(7)=0x22222222.
- Reset priority: reset=1 and reg_write=1, write_reg=9, write_data=0xA5A5A5A5 on the same edge; deassert reset → reading r9 returns 0.
- Exhaustive sweep: write register i with value i*0x01010101 for i=1..31, then read all pairs (i, 31−i) → each output equals the stored value one cycle after its address; r0 pair entries return 0.
